// File: rtl/i2s_rx_ctrl.sv
// i2s_rx_ctrl: I2S master receiver; HCLK/HRESET, en/chan_sel control, i2s_sck/i2s_ws/i2s_sd serial, sample_* valid/ready FIFO port, fifo_level/overrun/busy status
module i2s_rx_ctrl #(
  parameter int CLK_DIV        = 4,
  parameter int SAMPLE_BITS    = 24,
  parameter int FIFO_DEPTH     = 8,
  parameter int DISCARD_FRAMES = 2
) (
  input  logic                                 HCLK,
  input  logic                                 HRESET,
  input  logic                                 en,
  input  logic                                 chan_sel,
  input  logic                                 i2s_sd,
  output logic                                 i2s_sck,
  output logic                                 i2s_ws,
  output logic [SAMPLE_BITS-1:0]               sample_data,
  output logic                                 sample_valid,
  input  logic                                 sample_ready,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]      fifo_level,
  output logic                                 overrun,
  input  logic                                 ovr_clr,
  output logic                                 busy
);
  localparam int DW = $clog2(CLK_DIV);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(FIFO_DEPTH + 1);
  localparam int NW = $clog2(DISCARD_FRAMES + 2);
  typedef enum logic [1:0] {IDLE, SYNC, RUN, STOP} state_t;
  state_t                 r_state, w_state_nx;
  logic [DW-1:0]          r_div;
  logic                   r_sck, r_ws, r_chan_q, r_armed, r_ovr;
  logic [5:0]             r_bit;
  logic [NW-1:0]          r_disc;
  logic [SAMPLE_BITS-1:0] r_shreg;
  logic [SAMPLE_BITS-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]          r_wr, r_rd;
  logic [LW-1:0]          r_cnt;
  logic                   w_div_end, w_rise, w_fall, w_wrap, w_cap, w_push, w_full, w_pop, w_wr;
  logic [4:0]             w_pos;
  logic [5:0]             w_bit_nx;
  logic [SAMPLE_BITS-1:0] w_shift;
  assign w_div_end    = r_div == DW'(CLK_DIV - 1);
  assign w_rise       = r_state != IDLE && w_div_end && !r_sck;
  assign w_fall       = r_state != IDLE && w_div_end && r_sck;
  assign w_wrap       = w_fall && r_bit == 6'd63;
  assign w_bit_nx     = r_bit + 6'd1;
  assign w_pos        = r_bit[4:0];
  assign w_cap        = w_rise && w_pos != 5'd0 && w_pos <= 5'(SAMPLE_BITS);
  assign w_shift      = (r_shreg << 1) | SAMPLE_BITS'(i2s_sd);
  // r_armed lets the tail of a RUN frame still push after en drops; a stop from SYNC pushes nothing
  assign w_push       = w_rise && w_pos == 5'(SAMPLE_BITS) && r_ws == r_chan_q &&
                        (r_state == RUN || (r_state == STOP && r_armed));
  assign w_full       = r_cnt == LW'(FIFO_DEPTH);
  assign sample_valid = r_cnt != '0;
  assign w_pop        = sample_valid && sample_ready;
  assign w_wr         = w_push && (!w_full || w_pop);
  assign sample_data  = sample_valid ? r_mem[r_rd] : '0;
  assign i2s_sck      = r_sck;
  assign i2s_ws       = r_ws;
  assign fifo_level   = r_cnt;
  assign overrun      = r_ovr;
  assign busy         = r_state != IDLE;
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      IDLE:    if (en) w_state_nx = DISCARD_FRAMES == 0 ? RUN : SYNC;
      SYNC:    if (!en) w_state_nx = STOP;
               else if (w_wrap && r_disc == NW'(DISCARD_FRAMES)) w_state_nx = RUN;
      RUN:     if (!en) w_state_nx = STOP;
      STOP:    if (w_wrap) w_state_nx = IDLE;
      default: w_state_nx = IDLE;
    endcase
  end
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      r_state  <= IDLE;
      r_div    <= '0;
      r_sck    <= 1'b0;
      r_ws     <= 1'b0;
      r_bit    <= '0;
      r_disc   <= '0;
      r_chan_q <= 1'b0;
      r_armed  <= 1'b0;
      r_shreg  <= '0;
      r_wr     <= '0;
      r_rd     <= '0;
      r_cnt    <= '0;
      r_ovr    <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_armed <= r_state == RUN || (r_state == STOP && r_armed);
      if (r_state == IDLE) begin
        // preset to the last bit of a right slot so the first fall opens a left slot
        r_div  <= '0;
        r_sck  <= 1'b0;
        r_disc <= '0;
        r_bit  <= en ? 6'd63 : 6'd0;
        r_ws   <= en;
      end else begin
        r_div <= w_div_end ? '0 : r_div + 1'b1;
        if (w_div_end) r_sck <= !r_sck;
        if (w_fall) begin
          r_bit <= w_bit_nx;
          r_ws  <= w_bit_nx[5];
        end
        if (w_wrap) r_chan_q <= chan_sel;
        if (w_wrap && r_state == SYNC) r_disc <= r_disc + 1'b1;
      end
      if (w_cap) r_shreg <= w_shift;
      if (w_wr) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt <= r_cnt + LW'(w_wr) - LW'(w_pop);
      r_ovr <= (w_push && w_full && !w_pop) || (r_ovr && !ovr_clr);
    end
  end
  always_ff @(posedge HCLK) begin
    if (w_wr) r_mem[r_wr] <= w_shift;
  end
endmodule

// File: tb/tb_i2s_rx_ctrl.sv
// tb_i2s_rx_ctrl: directed bench for i2s_rx_ctrl with a microphone model driving sd on sck fall
module tb_i2s_rx_ctrl;
  logic        HCLK = 1'b0, HRESET = 1'b1, en = 1'b0, chan_sel = 1'b0, sample_ready = 1'b0, ovr_clr = 1'b0;
  logic        i2s_sd = 1'b0;
  logic        i2s_sck, i2s_ws, sample_valid, overrun, busy;
  logic [23:0] sample_data;
  logic [2:0]  fifo_level;
  int          n_checks = 0, n_fail = 0, cyc = 0, t0 = 0;
  logic [23:0] bfm_l = 24'hA5A5A5, bfm_r = 24'h123456, bfm_w;
  logic        bfm_seq = 1'b0, ws_r = 1'b0;
  int          seq_base = 0, n_rises = 0, pos = 0;

  i2s_rx_ctrl #(.CLK_DIV(2), .SAMPLE_BITS(24), .FIFO_DEPTH(4), .DISCARD_FRAMES(1)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .en(en), .chan_sel(chan_sel), .i2s_sd(i2s_sd),
    .i2s_sck(i2s_sck), .i2s_ws(i2s_ws), .sample_data(sample_data), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .fifo_level(fifo_level), .overrun(overrun), .ovr_clr(ovr_clr),
    .busy(busy));

  always #5 HCLK = ~HCLK;
  always @(posedge HCLK) cyc <= cyc + 1;

  // Microphone: samples ws on sck rise, counts bit position since the last ws change,
  // drives MSB one bit after the ws change on the sck fall. In sequence mode each left
  // word is n*0x100001, n = right slots seen since seq_base.
  always @(posedge i2s_sck) ws_r = i2s_ws;
  always @(negedge i2s_sck) begin
    #1;
    if (i2s_ws !== ws_r) begin
      pos = 0;
      if (i2s_ws) n_rises++;
    end else pos++;
    bfm_w = i2s_ws ? bfm_r : bfm_seq ? 24'(n_rises - seq_base) * 24'h100001 : bfm_l;
    i2s_sd = (pos >= 1 && pos <= 24) ? bfm_w[24-pos] : 1'b0;
  end

  task automatic do_reset();
    HRESET = 1'b1; en = 1'b0; chan_sel = 1'b0; sample_ready = 1'b0; ovr_clr = 1'b0; bfm_seq = 1'b0;
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic start();
    en = 1'b1;
    t0 = cyc;
  endtask

  task automatic to_k(input int k);
    while (cyc - t0 < k) @(negedge HCLK);
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (i2s_sck !== 1'b0) begin n_fail++; $display("FAIL rst_sck: got %b want 0", i2s_sck); end
    n_checks++; if (i2s_ws !== 1'b0) begin n_fail++; $display("FAIL rst_ws: got %b want 0", i2s_ws); end
    n_checks++; if (sample_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", sample_valid); end
    n_checks++; if (sample_data !== 24'h0) begin n_fail++; $display("FAIL rst_data: got %h want 0", sample_data); end
    n_checks++; if (fifo_level !== 3'd0) begin n_fail++; $display("FAIL rst_level: got %0d want 0", fifo_level); end
    n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rst_overrun: got %b want 0", overrun); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    repeat (5) @(negedge HCLK);
    n_checks++; if (busy !== 1'b0 || i2s_sck !== 1'b0) begin n_fail++; $display("FAIL idle_hold: got busy=%b sck=%b want 0 0", busy, i2s_sck); end
  endtask

  task automatic test_clocking();
    logic ps = 1'b0, pw = 1'b1;
    int   last_rise = -1, last_ws = -1, n_ws = 0;
    start();
    to_k(1);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL start_busy: got %b want 1", busy); end
    n_checks++; if (i2s_ws !== 1'b1 || i2s_sck !== 1'b0) begin n_fail++; $display("FAIL start_preset: got ws=%b sck=%b want 1 0", i2s_ws, i2s_sck); end
    for (int k = 2; k <= 400; k++) begin
      to_k(k);
      if (i2s_sck && !ps) begin
        if (last_rise >= 0) begin
          n_checks++; if (k - last_rise !== 4) begin n_fail++; $display("FAIL sck_period: got %0d want 4", k - last_rise); end
        end
        last_rise = k;
      end
      if (i2s_ws !== pw) begin
        n_checks++; if (!(ps && !i2s_sck)) begin n_fail++; $display("FAIL ws_edge: got sck %b->%b want 1->0", ps, i2s_sck); end
        if (last_ws < 0) begin
          n_checks++; if (k !== 5) begin n_fail++; $display("FAIL first_ws_fall: got cycle %0d want 5", k); end
        end else begin
          n_checks++; if (k - last_ws !== 128) begin n_fail++; $display("FAIL ws_half: got %0d want 128", k - last_ws); end
        end
        last_ws = k;
        n_ws++;
      end
      ps = i2s_sck;
      pw = i2s_ws;
    end
    n_checks++; if (n_ws !== 4) begin n_fail++; $display("FAIL ws_changes: got %0d want 4", n_ws); end
  endtask

  task automatic test_capture();
    int          ek [4] = '{359, 615, 999, 1255};
    logic [23:0] ed [4] = '{24'hA5A5A5, 24'hA5A5A5, 24'h123456, 24'h123456};
    int          n = 0;
    do_reset();
    bfm_l = 24'hA5A5A5;
    sample_ready = 1'b1;
    start();
    for (int k = 1; k <= 1300; k++) begin
      to_k(k);
      if (k == 620) chan_sel = 1'b1;
      if (sample_valid) begin
        if (n < 4) begin
          n_checks++;
          if (k !== ek[n] || sample_data !== ed[n]) begin
            n_fail++; $display("FAIL capture_%0d: got cycle %0d data %h want cycle %0d data %h", n, k, sample_data, ek[n], ed[n]);
          end
        end
        n++;
      end
    end
    n_checks++; if (n !== 4) begin n_fail++; $display("FAIL capture_count: got %0d want 4", n); end
  endtask

  task automatic test_overrun();
    do_reset();
    bfm_seq = 1'b1;
    seq_base = n_rises;
    start();
    to_k(360);
    n_checks++; if (fifo_level !== 3'd1 || sample_data !== 24'h100001) begin n_fail++; $display("FAIL ovr_first: got level %0d data %h want 1 100001", fifo_level, sample_data); end
    to_k(1128);
    n_checks++; if (fifo_level !== 3'd4 || overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_full: got level %0d ovr %b want 4 0", fifo_level, overrun); end
    to_k(1384);
    n_checks++; if (fifo_level !== 3'd4 || overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_drop: got level %0d ovr %b want 4 1", fifo_level, overrun); end
    n_checks++; if (sample_data !== 24'h100001) begin n_fail++; $display("FAIL ovr_head: got %h want 100001", sample_data); end
    to_k(1390);
    ovr_clr = 1'b1;
    to_k(1391);
    ovr_clr = 1'b0;
    n_checks++; if (overrun !== 1'b0 || fifo_level !== 3'd4) begin n_fail++; $display("FAIL ovr_clr: got ovr %b level %0d want 0 4", overrun, fifo_level); end
  endtask

  task automatic test_full_push_pop();
    logic [23:0] ew [4] = '{24'h200002, 24'h300003, 24'h400004, 24'h600006};
    to_k(1638);
    sample_ready = 1'b1;
    to_k(1639);
    sample_ready = 1'b0;
    n_checks++; if (fifo_level !== 3'd4 || overrun !== 1'b0) begin n_fail++; $display("FAIL full_pushpop: got level %0d ovr %b want 4 0", fifo_level, overrun); end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (sample_valid !== 1'b1 || sample_data !== ew[i]) begin
        n_fail++; $display("FAIL pop_%0d: got valid %b data %h want 1 %h", i, sample_valid, sample_data, ew[i]);
      end
      sample_ready = 1'b1;
      @(negedge HCLK);
      sample_ready = 1'b0;
    end
    n_checks++; if (sample_valid !== 1'b0 || fifo_level !== 3'd0 || sample_data !== 24'h0) begin n_fail++; $display("FAIL drained: got valid %b level %0d data %h want 0 0 0", sample_valid, fifo_level, sample_data); end
  endtask

  task automatic test_stop();
    int bad = 0;
    do_reset();
    bfm_l = 24'h5A5A5A;
    sample_ready = 1'b1;
    start();
    to_k(359);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 24'h5A5A5A) begin n_fail++; $display("FAIL stop_pre: got valid %b data %h want 1 5a5a5a", sample_valid, sample_data); end
    to_k(557);
    en = 1'b0;
    to_k(615);
    n_checks++; if (sample_valid !== 1'b1 || sample_data !== 24'h5A5A5A) begin n_fail++; $display("FAIL stop_tail: got valid %b data %h want 1 5a5a5a", sample_valid, sample_data); end
    to_k(772);
    n_checks++; if (busy !== 1'b1 || i2s_sck !== 1'b1) begin n_fail++; $display("FAIL stop_running: got busy %b sck %b want 1 1", busy, i2s_sck); end
    to_k(773);
    n_checks++; if (busy !== 1'b0 || i2s_sck !== 1'b0 || i2s_ws !== 1'b0) begin n_fail++; $display("FAIL stop_idle: got busy %b sck %b ws %b want 0 0 0", busy, i2s_sck, i2s_ws); end
    for (int k = 774; k <= 1100; k++) begin
      to_k(k);
      if (sample_valid || i2s_sck || busy) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stop_quiet: got %0d active cycles want 0", bad); end
  endtask

  task automatic test_reset_mid();
    int          first = -1;
    logic [23:0] fd = '0;
    do_reset();
    bfm_l = 24'h3C3C3C;
    start();
    to_k(616);
    n_checks++; if (fifo_level !== 3'd2) begin n_fail++; $display("FAIL mid_level: got %0d want 2", fifo_level); end
    to_k(678);
    HRESET = 1'b1;
    to_k(679);
    n_checks++; if (i2s_sck !== 1'b0 || i2s_ws !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_clk: got sck %b ws %b busy %b want 0 0 0", i2s_sck, i2s_ws, busy); end
    n_checks++; if (fifo_level !== 3'd0 || sample_valid !== 1'b0 || sample_data !== 24'h0 || overrun !== 1'b0) begin n_fail++; $display("FAIL mid_rst_fifo: got level %0d valid %b data %h ovr %b want 0 0 0 0", fifo_level, sample_valid, sample_data, overrun); end
    HRESET = 1'b0;
    t0 = cyc;
    for (int k = 1; k <= 360; k++) begin
      to_k(k);
      if (sample_valid && first < 0) begin
        first = k;
        fd = sample_data;
      end
    end
    n_checks++; if (first !== 359 || fd !== 24'h3C3C3C) begin n_fail++; $display("FAIL mid_restart: got cycle %0d data %h want 359 3c3c3c", first, fd); end
  endtask

  initial begin
    test_reset();
    test_clocking();
    test_capture();
    test_overrun();
    test_full_push_pop();
    test_stop();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
